// File: rtl/mem_ctrl.sv
// mem_ctrl: bridges the LC-3b core memory port to a req/ack word SRAM port.
// Each level-held core request becomes one physical word transaction. A watchdog aborts
// transactions that are never acknowledged. Define MEMCTRL_WBUF_EN to add a one-entry
// posted-write buffer that drains on the physical port independently of the core.
module mem_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic [15:0] ERR_RDATA   = 16'hDEAD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [1:0]  cpu_byte_enable,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_resp,
    output logic [15:0] cpu_rdata,
    output logic        phys_req,
    output logic        phys_we,
    output logic [14:0] phys_addr,
    output logic [1:0]  phys_wmask,
    output logic [15:0] phys_wdata,
    input  logic [15:0] phys_rdata,
    input  logic        phys_ack,
    output logic        timeout_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e         state_q, state_d;
    logic           gap_q, gap_d;
    logic           we_q, we_d;
    logic [14:0]    addr_q, addr_d;
    logic [1:0]     mask_q, mask_d;
    logic [15:0]    wdata_q, wdata_d;
    logic [15:0]    rdata_q, rdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           terr_q, terr_d;
    logic           can_sample;
    logic           req_active;
    logic           wd_expired;

    // Byte select within the word is carried by the mask, not the address.
    logic unused_addr0;
    assign unused_addr0 = cpu_address[0];

`ifdef MEMCTRL_WBUF_EN
    logic           wb_valid_q, wb_valid_d;
    logic [14:0]    wb_addr_q, wb_addr_d;
    logic [1:0]     wb_mask_q, wb_mask_d;
    logic [15:0]    wb_wdata_q, wb_wdata_d;
`endif

    // Next-state logic: request capture, watchdog, transaction sequencing.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        // Core drops its request in the cycle after resp; never sample there.
        gap_d   = (state_q == StResp);
`ifdef MEMCTRL_WBUF_EN
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_mask_d  = wb_mask_q;
        wb_wdata_d = wb_wdata_q;
        req_active = (state_q == StIssue) || wb_valid_q;
        // A pending drain holds off new requests so ordering is preserved.
        can_sample = !gap_q && !wb_valid_q;
`else
        req_active = (state_q == StIssue);
        can_sample = !gap_q;
`endif
        wd_expired = req_active && !phys_ack && (cnt_q == CntMax);

        if (req_active && !phys_ack) begin
            cnt_d = cnt_q + CntW'(1);
        end
        if (wd_expired) begin
            terr_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (can_sample && cpu_read) begin
                    state_d = StIssue;
                    we_d    = 1'b0;
                    addr_d  = cpu_address[15:1];
                    mask_d  = 2'b00;
                    wdata_d = cpu_wdata;
                    cnt_d   = '0;
                end else if (can_sample && cpu_write) begin
`ifdef MEMCTRL_WBUF_EN
                    // Posted: acknowledge the core now, drain in the background.
                    state_d    = StResp;
                    wb_valid_d = 1'b1;
                    wb_addr_d  = cpu_address[15:1];
                    wb_mask_d  = cpu_byte_enable;
                    wb_wdata_d = cpu_wdata;
                    cnt_d      = '0;
`else
                    state_d = StIssue;
                    we_d    = 1'b1;
                    addr_d  = cpu_address[15:1];
                    mask_d  = cpu_byte_enable;
                    wdata_d = cpu_wdata;
                    cnt_d   = '0;
`endif
                end
            end
            StIssue: begin
                if (phys_ack) begin
                    if (!we_q) begin
                        rdata_d = phys_rdata;
                    end
                    state_d = StResp;
                end else if (wd_expired) begin
                    if (!we_q) begin
                        rdata_d = ERR_RDATA;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef MEMCTRL_WBUF_EN
        // Drain completes on ack or is discarded by the watchdog.
        if (wb_valid_q && (phys_ack || wd_expired)) begin
            wb_valid_d = 1'b0;
        end
`endif
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gap_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
`ifdef MEMCTRL_WBUF_EN
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_mask_q  <= '0;
            wb_wdata_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
`ifdef MEMCTRL_WBUF_EN
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_mask_q  <= wb_mask_d;
            wb_wdata_q <= wb_wdata_d;
`endif
        end
    end

    // Outputs come straight from registers so they are glitch-free and stable.
    always_comb begin
        cpu_resp    = (state_q == StResp);
        cpu_rdata   = rdata_q;
        timeout_err = terr_q;
        phys_req    = req_active;
`ifdef MEMCTRL_WBUF_EN
        if (wb_valid_q) begin
            phys_we    = 1'b1;
            phys_addr  = wb_addr_q;
            phys_wmask = wb_mask_q;
            phys_wdata = wb_wdata_q;
        end else begin
            phys_we    = we_q;
            phys_addr  = addr_q;
            phys_wmask = mask_q;
            phys_wdata = wdata_q;
        end
`else
        phys_we    = we_q;
        phys_addr  = addr_q;
        phys_wmask = mask_q;
        phys_wdata = wdata_q;
`endif
    end

endmodule
